// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage data-bus master.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Size code 3 is illegal and behaves as a word, so bit 1 alone marks a word.
    function automatic logic size_is_word(input logic [1:0] size);
        return size[1];
    endfunction

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// Load lane selection and sign/zero extension of the raw read word.
module load_ext
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic signed [7:0]  byte_lane;
    logic signed [15:0] half_lane;

    function automatic logic [31:0] extend_byte(input logic signed [7:0] v, input logic uns);
        return uns ? {24'h000000, v} : 32'(v);
    endfunction

    function automatic logic [31:0] extend_half(input logic signed [15:0] v, input logic uns);
        return uns ? {16'h0000, v} : 32'(v);
    endfunction

    // Pick the addressed byte/half lane and widen it to 32 bits.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        if (size == SIZE_BYTE) begin
            result = extend_byte(byte_lane, is_unsigned);
        end else if (size == SIZE_HALF) begin
            result = extend_half(half_lane, is_unsigned);
        end else begin
            result = rdata;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage data-bus master: one request/response transaction per M-stage
// load/store, with M-stage stall generation, store lane replication and load
// extension.
// Optional feature macro: MEM_ALIGN_EXC_EN -- when defined, misaligned
// accesses raise adelM/adesM and issue no request; otherwise the low address
// bits are forced to alignment and the access proceeds.
module mem_access_unit
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_enM,
    input  logic        mem_write_enM,
    input  logic [31:0] mem_addrM,
    input  logic [31:0] rt_valueM,
    input  logic [1:0]  ls_sizeM,
    input  logic        ls_unsignedM,
    input  logic        excM,
    input  logic        ext_stallM,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] load_dataM,
    output logic        stall_o,
    output logic        adelM,
    output logic        adesM
);

    state_t      state;
    state_t      state_next;
    logic [31:0] load_r;
    logic [31:0] ext_data;
    logic        access;
    logic        is_half;
    logic        is_word;
    logic        align_block;
    logic        start;
    logic        rsp_done;

    assign access  = mem_read_enM | mem_write_enM;
    assign is_half = (ls_sizeM == SIZE_HALF);
    assign is_word = size_is_word(ls_sizeM);

`ifdef MEM_ALIGN_EXC_EN
    logic misalign;
    assign misalign    = (is_half & mem_addrM[0]) | (is_word & (mem_addrM[1:0] != 2'b00));
    assign align_block = misalign;
    assign adelM       = misalign & mem_read_enM;
    assign adesM       = misalign & mem_write_enM;
    assign data_addr   = mem_addrM;
`else
    assign align_block = 1'b0;
    assign adelM       = 1'b0;
    assign adesM       = 1'b0;
    assign data_addr   = {mem_addrM[31:2],
                          mem_addrM[1] & ~is_word,
                          mem_addrM[0] & ~(is_word | is_half)};
`endif

    assign start     = (state == ST_IDLE) & access & ~excM & ~align_block;
    assign rsp_done  = (state == ST_DATA) & data_data_ok;
    assign data_size = ls_sizeM;
    assign data_wr   = data_req & mem_write_enM;

    load_ext u_load_ext (
        .rdata       (data_rdata),
        .addr_lo     (mem_addrM[1:0]),
        .size        (ls_sizeM),
        .is_unsigned (ls_unsignedM),
        .result      (ext_data)
    );

    // Replicate the store source across every lane the access could hit.
    always_comb begin
        if (ls_sizeM == SIZE_BYTE) begin
            data_wdata = {4{rt_valueM[7:0]}};
        end else if (ls_sizeM == SIZE_HALF) begin
            data_wdata = {2{rt_valueM[15:0]}};
        end else begin
            data_wdata = rt_valueM;
        end
    end

    // Response data is forwarded in its arrival cycle, then held from load_r.
    assign load_dataM = rsp_done ? ext_data : load_r;

    // Transaction sequencing: request phase, response phase, post-response hold.
    always_comb begin
        state_next = state;
        data_req   = 1'b0;
        stall_o    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    data_req   = 1'b1;
                    stall_o    = 1'b1;
                    state_next = data_addr_ok ? ST_DATA : ST_ADDR;
                end
            end
            ST_ADDR: begin
                data_req = 1'b1;
                stall_o  = 1'b1;
                if (data_addr_ok) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (data_data_ok) begin
                    state_next = ext_stallM ? ST_HOLD : ST_IDLE;
                end else begin
                    stall_o = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!ext_stallM) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the extended load result; stores leave it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_r <= 32'h0;
        end else if (rsp_done && mem_read_enM) begin
            load_r <= ext_data;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios with literal
// expectations, then randomized pipeline/bus traffic against a transaction
// level reference model. Honours MEM_ALIGN_EXC_EN like the design.
`timescale 1ns/1ps
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_enM, mem_write_enM;
    logic [31:0] mem_addrM, rt_valueM;
    logic [1:0]  ls_sizeM;
    logic        ls_unsignedM, excM, ext_stallM;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata, load_dataM;
    logic        stall_o, adelM, adesM;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

`ifdef MEM_ALIGN_EXC_EN
    localparam bit ALIGN_EXC = 1'b1;
`else
    localparam bit ALIGN_EXC = 1'b0;
`endif

    // Reference model: a transaction is waiting for address acceptance,
    // waiting for its response, or finished but parked by an external stall.
    bit          m_wait_addr = 1'b0;
    bit          m_wait_data = 1'b0;
    bit          m_hold      = 1'b0;
    logic [31:0] m_load      = 32'h0;

    mem_access_unit dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read_enM  (mem_read_enM),
        .mem_write_enM (mem_write_enM),
        .mem_addrM     (mem_addrM),
        .rt_valueM     (rt_valueM),
        .ls_sizeM      (ls_sizeM),
        .ls_unsignedM  (ls_unsignedM),
        .excM          (excM),
        .ext_stallM    (ext_stallM),
        .data_req      (data_req),
        .data_wr       (data_wr),
        .data_size     (data_size),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_addr_ok  (data_addr_ok),
        .data_data_ok  (data_data_ok),
        .data_rdata    (data_rdata),
        .load_dataM    (load_dataM),
        .stall_o       (stall_o),
        .adelM         (adelM),
        .adesM         (adesM)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic view of load extension: shift the lane down, mask, and add
    // the sign fill when the top bit of the lane is set.
    function automatic logic [31:0] ref_ext(input logic [31:0] rd, input logic [1:0] a,
                                            input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (rd >> (8 * a)) & 32'h0000_00FF;
            if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (rd >> (16 * a[1])) & 32'h0000_FFFF;
            if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic bit ref_misalign();
        if (ls_sizeM == 2'd1) return mem_addrM[0];
        if (ls_sizeM >= 2'd2) return (mem_addrM % 4) != 0;
        return 1'b0;
    endfunction

    function automatic bit ref_issue();
        bit idle;
        idle = !(m_wait_addr || m_wait_data || m_hold);
        return idle && (mem_read_enM || mem_write_enM) && !excM && !(ALIGN_EXC && ref_misalign());
    endfunction

    // Compare process: every cycle, all outputs against the model.
    always @(negedge clk) begin
        logic        e_req;
        logic [31:0] e_addr, e_wd, e_ld;
        if (check_en) begin
            e_req = ref_issue() || m_wait_addr;
            if (ALIGN_EXC || ls_sizeM == 2'd0) e_addr = mem_addrM;
            else if (ls_sizeM == 2'd1) e_addr = mem_addrM - (mem_addrM % 2);
            else e_addr = mem_addrM - (mem_addrM % 4);
            if (ls_sizeM == 2'd0) e_wd = (rt_valueM & 32'hFF) * 32'h0101_0101;
            else if (ls_sizeM == 2'd1) e_wd = (rt_valueM & 32'hFFFF) * 32'h0001_0001;
            else e_wd = rt_valueM;
            e_ld = (m_wait_data && data_data_ok)
                   ? ref_ext(data_rdata, mem_addrM[1:0], ls_sizeM, ls_unsignedM) : m_load;
            chk("m_req",   {31'd0, data_req}, {31'd0, e_req});
            chk("m_wr",    {31'd0, data_wr},  {31'd0, e_req && mem_write_enM});
            chk("m_size",  {30'd0, data_size}, {30'd0, ls_sizeM});
            chk("m_addr",  data_addr, e_addr);
            chk("m_wdata", data_wdata, e_wd);
            chk("m_stall", {31'd0, stall_o},
                {31'd0, ref_issue() || m_wait_addr || (m_wait_data && !data_data_ok)});
            chk("m_load",  load_dataM, e_ld);
            chk("m_adel",  {31'd0, adelM}, {31'd0, ALIGN_EXC && ref_misalign() && mem_read_enM});
            chk("m_ades",  {31'd0, adesM}, {31'd0, ALIGN_EXC && ref_misalign() && mem_write_enM});
        end
    end

    // Model update at each active edge.
    always @(posedge clk) begin
        if (rst) begin
            m_wait_addr <= 1'b0;
            m_wait_data <= 1'b0;
            m_hold      <= 1'b0;
            m_load      <= 32'h0;
        end else if (ref_issue() || m_wait_addr) begin
            m_wait_addr <= !data_addr_ok;
            m_wait_data <= data_addr_ok;
        end else if (m_wait_data && data_data_ok) begin
            m_wait_data <= 1'b0;
            m_hold      <= ext_stallM;
            if (mem_read_enM)
                m_load <= ref_ext(data_rdata, mem_addrM[1:0], ls_sizeM, ls_unsignedM);
        end else if (m_hold && !ext_stallM) begin
            m_hold <= 1'b0;
        end
    end

    task automatic idle_inputs();
        mem_read_enM = 0; mem_write_enM = 0; mem_addrM = 0; rt_valueM = 0;
        ls_sizeM = 0; ls_unsignedM = 0; excM = 0; ext_stallM = 0;
        data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Load with immediate address acceptance and a response one cycle later.
    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                           input logic [31:0] rd, output logic [31:0] res);
        mem_read_enM = 1; mem_addrM = a; ls_sizeM = sz; ls_unsignedM = uns; data_addr_ok = 1;
        next();
        data_addr_ok = 0; data_data_ok = 1; data_rdata = rd;
        @(negedge clk);
        res = load_dataM;
        next();
        idle_inputs();
    endtask

    task automatic new_instr();
        int kind;
        kind = $urandom_range(0, 3);
        mem_read_enM  = (kind == 1 || kind == 2);
        mem_write_enM = (kind == 3);
        ls_sizeM      = 2'($urandom_range(0, 3));
        mem_addrM     = $urandom;
        if ($urandom_range(0, 3) != 0) begin
            if (ls_sizeM == 2'd1) mem_addrM[0] = 1'b0;
            else if (ls_sizeM >= 2'd2) mem_addrM[1:0] = 2'b00;
        end
        rt_valueM    = $urandom;
        ls_unsignedM = 1'($urandom_range(0, 1));
        excM         = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        logic [31:0] res;
        int          cnt;
        bit          adv;
        bit          outstanding;

        idle_inputs();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        check_en = 1;

        // Reset state
        @(negedge clk);
        chk("rst_req",   {31'd0, data_req}, 32'd0);
        chk("rst_wr",    {31'd0, data_wr},  32'd0);
        chk("rst_stall", {31'd0, stall_o},  32'd0);
        chk("rst_load",  load_dataM, 32'h0);
        chk("rst_adel",  {31'd0, adelM}, 32'd0);
        chk("rst_ades",  {31'd0, adesM}, 32'd0);
        next();

        // LW 0x8000_0010: accepted cycle 0, response cycle 2
        mem_read_enM = 1; ls_sizeM = 2; mem_addrM = 32'h8000_0010; data_addr_ok = 1;
        @(negedge clk);
        chk("lw_c0_req",   {31'd0, data_req}, 32'd1);
        chk("lw_c0_stall", {31'd0, stall_o},  32'd1);
        next();
        data_addr_ok = 0;
        @(negedge clk);
        chk("lw_c1_req",   {31'd0, data_req}, 32'd0);
        chk("lw_c1_stall", {31'd0, stall_o},  32'd1);
        next();
        data_data_ok = 1; data_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("lw_c2_stall", {31'd0, stall_o}, 32'd0);
        chk("lw_c2_load",  load_dataM, 32'h1234_5678);
        next();
        idle_inputs();
        @(negedge clk);
        chk("lw_held_load", load_dataM, 32'h1234_5678);
        next();

        // Byte / half extension
        do_load(32'h8000_0003, 2'd0, 1'b0, 32'h80FF_FF7F, res);
        chk("lb_sign", res, 32'hFFFF_FF80);
        do_load(32'h8000_0003, 2'd0, 1'b1, 32'h80FF_FF7F, res);
        chk("lbu_zero", res, 32'h0000_0080);
        do_load(32'h8000_0002, 2'd1, 1'b0, 32'h80FF_FF7F, res);
        chk("lh_sign", res, 32'hFFFF_80FF);

        // SH 0x...02
        cnt = 0;
        mem_write_enM = 1; ls_sizeM = 1; mem_addrM = 32'h8000_0102; rt_valueM = 32'hAAAA_BEEF;
        data_addr_ok = 1;
        @(negedge clk);
        chk("sh_wr",    {31'd0, data_wr}, 32'd1);
        chk("sh_size",  {30'd0, data_size}, 32'd1);
        chk("sh_wdata", data_wdata, 32'hBEEF_BEEF);
        cnt += int'(data_req);
        next();
        data_addr_ok = 0;
        @(negedge clk);
        cnt += int'(data_req);
        next();
        data_data_ok = 1;
        @(negedge clk);
        cnt += int'(data_req);
        chk("sh_stall_end", {31'd0, stall_o}, 32'd0);
        next();
        idle_inputs();
        chk("sh_one_req", cnt, 1);

        // Address acceptance withheld three cycles
        cnt = 0;
        mem_read_enM = 1; ls_sizeM = 2; mem_addrM = 32'h8000_0020;
        for (int i = 0; i < 4; i++) begin
            data_addr_ok = (i == 3);
            @(negedge clk);
            if (data_req && stall_o && data_addr == 32'h8000_0020 && !data_wr) cnt++;
            next();
        end
        chk("wait_req_cycles", cnt, 4);
        data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        chk("wait_load", load_dataM, 32'h0BAD_F00D);
        next();
        idle_inputs();

        // Misaligned LW 0x...01
        mem_read_enM = 1; ls_sizeM = 2; mem_addrM = 32'h8000_0031;
`ifdef MEM_ALIGN_EXC_EN
        @(negedge clk);
        chk("mis_adel",  {31'd0, adelM},    32'd1);
        chk("mis_req",   {31'd0, data_req}, 32'd0);
        chk("mis_stall", {31'd0, stall_o},  32'd0);
        next();
`else
        data_addr_ok = 1;
        @(negedge clk);
        chk("mis_addr", data_addr, 32'h8000_0030);
        chk("mis_req",  {31'd0, data_req}, 32'd1);
        next();
        data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h5555_AAAA;
        next();
`endif
        idle_inputs();

        // Response under external stall: parked, no re-issue
        mem_read_enM = 1; ls_sizeM = 2; mem_addrM = 32'h8000_0040; data_addr_ok = 1;
        next();
        data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hCAFE_F00D; ext_stallM = 1;
        @(negedge clk);
        chk("hold_first_load", load_dataM, 32'hCAFE_F00D);
        next();
        data_data_ok = 0; data_rdata = 32'h0;
        for (int i = 0; i < 2; i++) begin
            ext_stallM = (i == 0);
            @(negedge clk);
            chk("hold_req",   {31'd0, data_req}, 32'd0);
            chk("hold_load",  load_dataM, 32'hCAFE_F00D);
            chk("hold_stall", {31'd0, stall_o}, 32'd0);
            next();
        end
        idle_inputs();

        // Exception on a load: no request
        mem_read_enM = 1; ls_sizeM = 2; mem_addrM = 32'h8000_0050; excM = 1;
        @(negedge clk);
        chk("exc_req",   {31'd0, data_req}, 32'd0);
        chk("exc_stall", {31'd0, stall_o},  32'd0);
        next();
        idle_inputs();

        // Reset in the middle of a request phase
        mem_read_enM = 1; ls_sizeM = 2; mem_addrM = 32'h8000_0060;
        next();
        rst = 1; mem_read_enM = 0;
        next();
        rst = 0;
        @(negedge clk);
        chk("rst_mid_req",  {31'd0, data_req}, 32'd0);
        chk("rst_mid_load", load_dataM, 32'h0);
        next();
        idle_inputs();

        // Randomized pipeline traffic with a protocol-respecting bus slave
        adv = 1;
        outstanding = 0;
        for (int c = 0; c < 4000; c++) begin
            if (adv) new_instr();
            ext_stallM = ($urandom_range(0, 3) == 0);
            data_rdata = $urandom;
            #1;
            data_addr_ok = data_req && ($urandom_range(0, 2) != 0);
            data_data_ok = outstanding && ($urandom_range(0, 2) != 0);
            @(negedge clk);
            adv = !stall_o && !ext_stallM;
            if (data_data_ok) outstanding = 0;
            if (data_req && data_addr_ok) outstanding = 1;
            next();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
